iagu_depthconv: RTL and testbench

// - Feature-map address generator (IAGU) for depthwise convolution (mode 5). Sits directly upstream of WaguDepthConvolution.
// - Streams the K input rows needed for one output row of one channel piece from the feature buffer into the NPE.
// - Pulses o_feature_load_end when a window is loaded, then waits for i_group_end from the WAGU before loading the next window.

---
 rtl/iagu_depthconv.sv | 220 ++++++++++++++++++++++
 tb/tb_iagu_depthconv.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iagu_depthconv.sv
// Feature-map address generator for depthwise convolution (mode 5).
// Optional read-beat statistics counter: DEPTHCONV_IAGU_STAT_EN.
module iagu_depthconv #(
  parameter int ADDR_W = 13,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_calculate,
  input  logic [3:0]        mode,
  input  logic [ADDR_W-1:0] addr_start_f,
  input  logic [LEN_W-1:0]  in_y_length,
  input  logic [LEN_W-1:0]  in_piece,
  input  logic [LEN_W-1:0]  out_y_length,
  input  logic [3:0]        i_kernel,
  input  logic [1:0]        i_stride,
  input  logic [1:0]        i_pad,
  input  logic              i_group_end,
  output logic [ADDR_W-1:0] o_f_addr,
  output logic              o_rd_en,
  output logic              o_pad_zero,
  output logic              o_feature_load_end,
  output logic              o_busy,
  output logic              o_done,
  output logic [CNT_W-1:0]  o_rd_count
);

  localparam int IW = LEN_W + 4;
  localparam int CW = LEN_W + 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_LDEND = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // a*k for k in 0..3 as shift-add
  function automatic logic [ADDR_W-1:0] mul3(
    input logic [LEN_W-1:0] a,
    input logic [1:0]       k
  );
    logic [ADDR_W-1:0] ax;
    ax = ADDR_W'(a);
    mul3 = (k[0] ? ax : '0) + (k[1] ? (ax << 1) : '0);
  endfunction

  logic [2:0]        state;
  logic [LEN_W-1:0]  w_q, np_q, ny_q;
  logic [3:0]        k_q;
  logic [1:0]        s_q, p_q;
  logic [ADDR_W-1:0] ww_q, pw_q, sw_q;
  logic [CW-1:0]     cw_q;
  logic [LEN_W-1:0]  pc_q, oy_q;
  logic [3:0]        ky_q;
  logic [CW-1:0]     c_q;
  logic signed [IW-1:0] iy0_q, iy_q, ix_q;
  logic [ADDR_W-1:0] pbase_q, row0_q, row_q, last_q;
  logic              grp_q;

  logic signed [IW-1:0] ws, ps, ss, ps_in;
  logic              pad, rd, accept, degen;
  logic              last_c, last_ky, last_oy, last_p, go;
  logic [ADDR_W-1:0] beat_addr, pw_in;
  logic [ADDR_W-1:0] nxt_pbase, nxt_row0;
  logic signed [IW-1:0] nxt_iy0;

  assign ws    = signed'(IW'(w_q));
  assign ps    = signed'(IW'(p_q));
  assign ss    = signed'(IW'(s_q));
  assign ps_in = signed'(IW'(i_pad));
  assign pw_in = mul3(in_y_length, i_pad);

  assign pad = (iy_q < 0) || (iy_q >= ws) || (ix_q < 0) || (ix_q >= ws);
  assign rd  = (state == S_LOAD) && !pad;
  assign beat_addr = row_q + ADDR_W'(ix_q);

  assign accept = start_calculate && (mode == 4'd5) && (state == S_IDLE);
  assign degen  = (i_kernel == 4'd0) || (i_stride == 2'd0) ||
                  (in_piece == '0) || (out_y_length == '0) ||
                  ((in_y_length == '0) && (i_pad == 2'd0));

  assign last_c  = (c_q == cw_q - CW'(1));
  assign last_ky = (ky_q == k_q - 4'd1);
  assign last_oy = (oy_q == ny_q - LEN_W'(1));
  assign last_p  = (pc_q == np_q - LEN_W'(1));
  assign go      = grp_q || i_group_end;

  always_comb begin
    nxt_pbase = pbase_q;
    nxt_iy0   = iy0_q + ss;
    nxt_row0  = row0_q + sw_q;
    if (last_oy) begin
      nxt_pbase = pbase_q + ww_q;
      nxt_iy0   = -ps;
      nxt_row0  = pbase_q + ww_q - pw_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      w_q     <= '0;
      np_q    <= '0;
      ny_q    <= '0;
      k_q     <= '0;
      s_q     <= '0;
      p_q     <= '0;
      ww_q    <= '0;
      pw_q    <= '0;
      sw_q    <= '0;
      cw_q    <= '0;
      pc_q    <= '0;
      oy_q    <= '0;
      ky_q    <= '0;
      c_q     <= '0;
      iy0_q   <= '0;
      iy_q    <= '0;
      ix_q    <= '0;
      pbase_q <= '0;
      row0_q  <= '0;
      row_q   <= '0;
      last_q  <= '0;
      grp_q   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            w_q     <= in_y_length;
            np_q    <= in_piece;
            ny_q    <= out_y_length;
            k_q     <= i_kernel;
            s_q     <= i_stride;
            p_q     <= i_pad;
            ww_q    <= ADDR_W'(in_y_length) * ADDR_W'(in_y_length);
            pw_q    <= pw_in;
            sw_q    <= mul3(in_y_length, i_stride);
            cw_q    <= CW'(in_y_length) + CW'({i_pad, 1'b0});
            pc_q    <= '0;
            oy_q    <= '0;
            ky_q    <= '0;
            c_q     <= '0;
            iy0_q   <= -ps_in;
            iy_q    <= -ps_in;
            ix_q    <= -ps_in;
            pbase_q <= addr_start_f;
            row0_q  <= addr_start_f - pw_in;
            row_q   <= addr_start_f - pw_in;
            grp_q   <= 1'b0;
            state   <= degen ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          grp_q <= grp_q | i_group_end;
          if (rd) last_q <= beat_addr;
          if (!last_c) begin
            c_q  <= c_q + CW'(1);
            ix_q <= ix_q + IW'(1);
          end else begin
            c_q   <= '0;
            ix_q  <= -ps;
            ky_q  <= ky_q + 4'd1;
            iy_q  <= iy_q + IW'(1);
            row_q <= row_q + ADDR_W'(w_q);
            if (last_ky) state <= S_LDEND;
          end
        end
        S_LDEND: begin
          grp_q <= grp_q | i_group_end;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (go) begin
            grp_q <= 1'b0;
            if (last_oy && last_p) begin
              state <= S_DONE;
            end else begin
              pc_q    <= last_oy ? pc_q + LEN_W'(1) : pc_q;
              oy_q    <= last_oy ? '0 : oy_q + LEN_W'(1);
              pbase_q <= nxt_pbase;
              iy0_q   <= nxt_iy0;
              row0_q  <= nxt_row0;
              iy_q    <= nxt_iy0;
              row_q   <= nxt_row0;
              ix_q    <= -ps;
              ky_q    <= '0;
              c_q     <= '0;
              state   <= S_LOAD;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_f_addr           = rd ? beat_addr : last_q;
  assign o_rd_en            = rd;
  assign o_pad_zero         = (state == S_LOAD) && pad;
  assign o_feature_load_end = (state == S_LDEND);
  assign o_busy             = (state == S_LOAD) || (state == S_LDEND) ||
                              (state == S_WAIT);
  assign o_done             = (state == S_DONE);

`ifdef DEPTHCONV_IAGU_STAT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else if (accept) cnt_q <= '0;
    else if (rd && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
  end

  assign o_rd_count = cnt_q;
`else
  assign o_rd_count = '0;
`endif

endmodule

// File: tb/tb_iagu_depthconv.sv
// Directed self-checking bench for iagu_depthconv.
module tb_iagu_depthconv;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_calculate;
  logic [3:0]  mode;
  logic [12:0] addr_start_f;
  logic [7:0]  in_y_length, in_piece, out_y_length;
  logic [3:0]  i_kernel;
  logic [1:0]  i_stride, i_pad;
  logic        i_group_end;
  logic [12:0] o_f_addr;
  logic        o_rd_en, o_pad_zero, o_feature_load_end;
  logic        o_busy, o_done;
  logic [15:0] o_rd_count;

  int n_asrt = 0;
  int n_fail = 0;
  int b_addr[$];
  int b_pad[$];
  int bubbles;
  int seen_le;

  iagu_depthconv dut (
    .clk(clk), .rst(rst),
    .start_calculate(start_calculate), .mode(mode),
    .addr_start_f(addr_start_f), .in_y_length(in_y_length),
    .in_piece(in_piece), .out_y_length(out_y_length),
    .i_kernel(i_kernel), .i_stride(i_stride), .i_pad(i_pad),
    .i_group_end(i_group_end), .o_f_addr(o_f_addr),
    .o_rd_en(o_rd_en), .o_pad_zero(o_pad_zero),
    .o_feature_load_end(o_feature_load_end),
    .o_busy(o_busy), .o_done(o_done), .o_rd_count(o_rd_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Records beats until the load-end pulse (left visible on return).
  task automatic collect(input int budget);
    b_addr.delete();
    b_pad.delete();
    bubbles = 0;
    seen_le = 0;
    for (int k = 0; k < budget; k++) begin
      if (o_feature_load_end === 1'b1) begin
        seen_le = 1;
        break;
      end
      if (o_rd_en === 1'b1 && o_pad_zero === 1'b0) begin
        b_addr.push_back(int'(o_f_addr));
        b_pad.push_back(0);
      end else if (o_rd_en === 1'b0 && o_pad_zero === 1'b1) begin
        b_addr.push_back(int'(o_f_addr));
        b_pad.push_back(1);
      end else begin
        bubbles++;
      end
      tick();
    end
    chk("load_end_seen", seen_le, 1);
    chk("no_bubbles", bubbles, 0);
  endtask

  task automatic set_cfg(input int base, input int w, input int np,
                         input int ny, input int k, input int s,
                         input int p);
    addr_start_f = 13'(base);
    in_y_length  = 8'(w);
    in_piece     = 8'(np);
    out_y_length = 8'(ny);
    i_kernel     = 4'(k);
    i_stride     = 2'(s);
    i_pad        = 2'(p);
  endtask

  task automatic pulse_start(input int m);
    mode = 4'(m);
    start_calculate = 1'b1;
    tick();
    start_calculate = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_addr"}, o_f_addr, 0);
    chk({tag, "_rd"}, o_rd_en, 0);
    chk({tag, "_pad"}, o_pad_zero, 0);
    chk({tag, "_le"}, o_feature_load_end, 0);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_done, 0);
  endtask

  initial begin
    int errs, first, total, iy, ix, ep, ea;
    rst = 1'b1;
    start_calculate = 1'b0;
    mode = 4'd0;
    i_group_end = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    check_idle_zero("reset");
    chk("reset_cnt", o_rd_count, 0);
    rst = 1'b0;
    tick();

    // Test 1: W=5 pieces=2 out=3 K=3 S=1 P=0 base=0
    set_cfg(0, 5, 2, 3, 3, 1, 0);
    pulse_start(5);
    chk("t1_busy", o_busy, 1);
    total = 0;
    for (int w = 0; w < 6; w++) begin
      first = (w / 3) * 25 + (w % 3) * 5;
      collect(100);
      chk("t1_beats", b_addr.size(), 15);
      errs = 0;
      foreach (b_addr[i]) begin
        if (b_addr[i] != first + i || b_pad[i] != 0) errs++;
        total += (b_pad[i] == 0) ? 1 : 0;
      end
      chk("t1_addr_seq", errs, 0);
      if (b_addr.size() > 0) chk("t1_first", b_addr[0], first);
      tick();
      chk("t1_wait_rd", o_rd_en, 0);
      chk("t1_le_1cyc", o_feature_load_end, 0);
      chk("t1_wait_busy", o_busy, 1);
      i_group_end = 1'b1;
      tick();
      i_group_end = 1'b0;
    end
    chk("t1_total", total, 90);
    chk("t1_done", o_done, 1);
    chk("t1_done_busy", o_busy, 0);
`ifdef DEPTHCONV_IAGU_STAT_EN
    chk("t1_count", o_rd_count, 90);
`else
    chk("t1_count", o_rd_count, 0);
`endif
    tick();
    chk("t1_done_1cyc", o_done, 0);

    // Test 2: W=4 out=4 K=3 S=1 P=1 base=100, window 0 only
    set_cfg(100, 4, 1, 4, 3, 1, 1);
    pulse_start(5);
    collect(100);
    chk("t2_beats", b_addr.size(), 18);
    if (b_addr.size() == 18) begin
      for (int i = 0; i < 18; i++) begin
        iy = i / 6 - 1;
        ix = i % 6 - 1;
        ep = (iy < 0 || iy >= 4 || ix < 0 || ix >= 4) ? 1 : 0;
        ea = 100 + iy * 4 + ix;
        chk($sformatf("t2_pad%0d", i), b_pad[i], ep);
        if (ep == 0) chk($sformatf("t2_addr%0d", i), b_addr[i], ea);
      end
      chk("t2_hold11", b_addr[11], 103);
      chk("t2_hold17", b_addr[17], 107);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("t2_rst");

    // Test 3: W=5 out=2 K=3 S=2 P=0 base=200, early group_end
    set_cfg(200, 5, 1, 2, 3, 2, 0);
    pulse_start(5);
    chk("t3_b0_rd", o_rd_en, 1);
    chk("t3_b0_addr", o_f_addr, 200);
    i_group_end = 1'b1;
    tick();
    i_group_end = 1'b0;
    collect(100);
    chk("t3_w0_beats", b_addr.size(), 14);
    tick();
    chk("t3_wait_rd", o_rd_en, 0);
    chk("t3_wait_busy", o_busy, 1);
    tick();
    collect(100);
    chk("t3_w1_beats", b_addr.size(), 15);
    if (b_addr.size() == 15) begin
      chk("t3_w1_first", b_addr[0], 210);
      chk("t3_w1_last", b_addr[14], 224);
    end
    tick();
    i_group_end = 1'b1;
    tick();
    i_group_end = 1'b0;
    chk("t3_done", o_done, 1);
    tick();

    // Test 4: reset mid-LOAD of window 1, then restart
    pulse_start(5);
    collect(100);
    tick();
    i_group_end = 1'b1;
    tick();
    i_group_end = 1'b0;
    chk("t4_w1_first", o_f_addr, 210);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle_zero("t4_rst");
    chk("t4_rst_cnt", o_rd_count, 0);
    tick();
    chk("t4_no_done", o_done, 0);
    chk("t4_idle_busy", o_busy, 0);
    pulse_start(5);
    chk("t4_restart_rd", o_rd_en, 1);
    chk("t4_restart_addr", o_f_addr, 200);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Test 5: mode=4 ignored, K=0 degenerate
    pulse_start(4);
    chk("t5_m4_busy", o_busy, 0);
    chk("t5_m4_rd", o_rd_en, 0);
    chk("t5_m4_done", o_done, 0);
    tick();
    chk("t5_m4_done2", o_done, 0);
    set_cfg(0, 5, 1, 2, 0, 1, 0);
    pulse_start(5);
    chk("t5_k0_done", o_done, 1);
    chk("t5_k0_rd", o_rd_en, 0);
    chk("t5_k0_busy", o_busy, 0);
    chk("t5_k0_cnt", o_rd_count, 0);
    tick();
    chk("t5_k0_done_1cyc", o_done, 0);
    chk("t5_k0_rd2", o_rd_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
